uim_bank: RTL and testbench
===========================

# uim_bank

Parametrised, runtime-configurable bank of UIM (universal interconnect matrix) switches for the CPLD simulation model. Each of `CHANNELS` outputs is driven by a priority-fuse selector choosing one of `SEL_W+1` candidate inputs. Fuse bits are loaded serially into a shadow register and committed atomically to the active fuse set. The bank sits between the macrocell/pin feedback buses and the logic-block product-term inputs.

## Interface
- `CHANNELS`, 8: number of UIM output channels.
- `SEL_W`, 5: fuse bits per channel; each channel has `SEL_W+1` candidates.
- `REG_OUT`, 0: 1 = registered outputs; 0 = combinational from active fuses.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `cfg_start`  in  1  pulse; clears bit count, enters SHIFT.
- `cfg_valid`  in  1  serial fuse bit valid.
- `cfg_bit`  in  1  serial fuse bit.
- `cfg_ready`  out  1  high only in SHIFT.
- `cfg_commit`  in  1  pulse; copies shadow to active.
- `cfg_done`  out  1  level; high in FULL.
- `cfg_err`  out  1  one-cycle pulse on a rejected commit.
- `in_bus`  in  `CHANNELS*(SEL_W+1)`  candidates; channel c occupies bits `[c*(SEL_W+1) +: SEL_W+1]`, candidate 0 = LSB.
- `q`  out  `CHANNELS`  selected value per channel.

## Operation
- Fuse vector: `TOTAL = CHANNELS*SEL_W` bits. Channel c's fuses are `active[c*SEL_W +: SEL_W]`.
- Decode per channel, with f = fuse field, scanning from MSB down:
  - first 0 at bit position k selects candidate `SEL_W-1-k`;
  - all ones (erased) selects candidate `SEL_W` (default);
  - a higher-order 0 always wins over any lower-order 0.
- FSM states: IDLE, SHIFT, FULL.
  - IDLE: cfg_start -> SHIFT, count <= 0.
  - SHIFT: each cycle with `cfg_valid` high shifts shadow left with `cfg_bit` into the LSB and increments count. When count reaches TOTAL on that cycle -> FULL.
  - FULL: cfg_commit -> `active <= shadow`, go to IDLE.
- The first bit shifted ends at `shadow[TOTAL-1]`, the MSB of channel CHANNELS-1.
- cfg_start in any state restarts:
  - count <= 0, shadow unchanged until overwritten;
  - go to SHIFT;
  - a same-cycle cfg_valid bit is discarded;
  - a same-cycle cfg_commit is ignored and no error is raised.
- cfg_commit outside FULL (and not coincident with cfg_start): `cfg_err` pulses high the next cycle. Active fuses and state are unchanged.
- cfg_valid outside SHIFT is ignored.
- Count width: `$clog2(TOTAL+1)`. Count never exceeds TOTAL.
- The shadow can be partially reloaded and the load aborted without disturbing active fuses. Routing changes only on commit.

## Timing
- Reset values:
  - state IDLE, count 0;
  - shadow and active all ones (every channel selects candidate SEL_W);
  - cfg_ready 0, cfg_done 0, cfg_err 0.
  - q: 0 if REG_OUT=1. If REG_OUT=0, q equals the default candidates.
- cfg_ready and cfg_done are registered state decodes. cfg_ready falls the cycle after the TOTAL-th bit is accepted, and cfg_done rises on that same cycle.
- Commit takes effect at the commit edge.
  - REG_OUT=0: q reflects the new routing in the following cycle, combinationally from in_bus.
  - REG_OUT=1: q reflects it one edge later.
  - REG_OUT=1: in_bus-to-q latency is 1 cycle.
- Reset mid-load or mid-commit: reset wins and all state returns to reset values, including active.

## Structure
- Package `uim_pkg` holds:
  - the FSM state typedef (IDLE/SHIFT/FULL);
  - the `uim_total(channels, sel_w)` constant function.
- Sub-module `uim_sel` (parameter `SEL_W`) is a single-channel combinational priority decoder. It is instantiated CHANNELS times by generate.
- Shadow register, active register, count, FSM and the optional output register live in `uim_bank`.

## Test plan
All scenarios use CHANNELS=2, SEL_W=5, so TOTAL=10.
- Reset, no config: in_bus = 12'b100000_100000 -> q=2'b11 (candidate 5 per channel). With REG_OUT=1, q=0 during reset.
- cfg_start, shift 0111111111, commit -> ch1 fuse 01111 selects candidate 0, ch0 fuse 11111 selects 5. Then in_bus=12'b000001_100000 -> q=2'b11. cfg_done is high for exactly the cycles between the 10th bit and commit.
- Priority: ch0 fuse 11010 -> candidate 2, not 4. Toggling only in_bus bit 2 toggles q[0].
- Commit after 7 bits -> cfg_err pulses one cycle, q routing unchanged, state stays SHIFT.
- Abort and simultaneous events:
  - cfg_start coincident with cfg_valid and cfg_commit in FULL -> no err, count=0, old routing kept.
  - A full reload then commits correctly.
- rst asserted after 4 bits, then a commit attempt -> cfg_err pulses, active stays all ones, q = default candidates.

Source files
------------

// File: rtl/uim_pkg.sv
// Shared types and constants for the UIM switch bank.
// Only elaboration-time content: the FSM state type and the fuse-vector size helper.
package uim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2
   } uim_state_t;

   function automatic int uim_total(input int channels, input int sel_w);
      return channels * sel_w;
   endfunction

endpackage

// File: rtl/uim_sel.sv
// Single-channel priority-fuse selector: picks one of SEL_W+1 candidates, purely combinational.
// An erased (all-ones) field routes the default candidate SEL_W.
module uim_sel #(
   parameter int SEL_W = 5
) (
   input  logic [SEL_W-1:0] fuse,
   input  logic [SEL_W:0]   cand,
   output logic             q
);

   // Scan upward so a higher-order blown fuse overrides every lower one.
   always_comb begin
      q = cand[SEL_W];
      for (int k = 0; k < SEL_W; k++) begin
         if (!fuse[k]) q = cand[SEL_W-1-k];
      end
   end

endmodule

// File: rtl/uim_bank.sv
// Bank of CHANNELS UIM selectors with serial shadow fuse load and atomic commit to the active set.
// q is combinational from in_bus, or one cycle late when REG_OUT=1; cfg_ready paces the loader.
module uim_bank
   import uim_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 5,
   parameter int REG_OUT  = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_start,
   input  logic                          cfg_valid,
   input  logic                          cfg_bit,
   output logic                          cfg_ready,
   input  logic                          cfg_commit,
   output logic                          cfg_done,
   output logic                          cfg_err,
   input  logic [CHANNELS*(SEL_W+1)-1:0] in_bus,
   output logic [CHANNELS-1:0]           q
);

   localparam int TOTAL  = uim_total(CHANNELS, SEL_W);
   localparam int CW     = $clog2(TOTAL + 1);
   localparam int CAND_W = SEL_W + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

   uim_state_t          state;
   uim_state_t          next_state;
   logic [CW-1:0]       count;
   logic [TOTAL-1:0]    shadow;
   logic [TOTAL-1:0]    active;
   logic                err_r;
   logic [CHANNELS-1:0] q_sel;

   // cfg_start has priority over every other control input in the same cycle.
   logic bit_acc;
   logic commit_ok;
   logic commit_bad;

   assign bit_acc    = (state == ST_SHIFT) && cfg_valid && !cfg_start;
   assign commit_ok  = (state == ST_FULL) && cfg_commit && !cfg_start;
   assign commit_bad = (state != ST_FULL) && cfg_commit && !cfg_start;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (cfg_start) begin
         next_state = ST_SHIFT;
      end else begin
         case (state)
            ST_SHIFT: if (bit_acc && count == LAST_IDX) next_state = ST_FULL;
            ST_FULL:  if (commit_ok) next_state = ST_IDLE;
            default:  next_state = state;
         endcase
      end
   end

   always_comb begin
      cfg_ready = (state == ST_SHIFT);
      cfg_done  = (state == ST_FULL);
      cfg_err   = err_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         shadow <= '1;
         active <= '1;
         err_r  <= 1'b0;
      end else begin
         err_r <= commit_bad;
         if (cfg_start)    count <= '0;
         else if (bit_acc) count <= count + 1'b1;
         if (bit_acc)   shadow <= {shadow[TOTAL-2:0], cfg_bit};
         if (commit_ok) active <= shadow;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      uim_sel #(.SEL_W(SEL_W)) u_sel (
         .fuse (active[c*SEL_W +: SEL_W]),
         .cand (in_bus[c*CAND_W +: CAND_W]),
         .q    (q_sel[c])
      );
   end

   if (REG_OUT != 0) begin : g_reg_out
      logic [CHANNELS-1:0] q_r;
      always_ff @(posedge clk) begin
         if (rst) q_r <= '0;
         else     q_r <= q_sel;
      end
      assign q = q_r;
   end else begin : g_comb_out
      assign q = q_sel;
   end

endmodule

// File: tb/tb_uim_bank.sv
// Directed bench for uim_bank (2 channels x 5 fuses) with a combinational and a registered instance.
module tb_uim_bank;

   localparam int CH  = 2;
   localparam int SW  = 5;
   localparam int TOT = CH * SW;

   logic            clk;
   logic            rst;
   logic            cfg_start;
   logic            cfg_valid;
   logic            cfg_bit;
   logic            cfg_commit;
   logic [11:0]     in_bus;
   logic            ready0, done0, err0;
   logic            ready1, done1, err1;
   logic [CH-1:0]   q0, q1;

   int checks = 0;
   int errors = 0;
   bit running = 1'b1;

   uim_bank #(.CHANNELS(CH), .SEL_W(SW), .REG_OUT(0)) dut0 (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_bit(cfg_bit), .cfg_ready(ready0), .cfg_commit(cfg_commit),
      .cfg_done(done0), .cfg_err(err0), .in_bus(in_bus), .q(q0)
   );

   uim_bank #(.CHANNELS(CH), .SEL_W(SW), .REG_OUT(1)) dut1 (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
      .cfg_bit(cfg_bit), .cfg_ready(ready1), .cfg_commit(cfg_commit),
      .cfg_done(done1), .cfg_err(err1), .in_bus(in_bus), .q(q1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Candidate index chosen by a fuse field: first 0 from the MSB, else the default.
   function automatic int dec(input logic [SW-1:0] f);
      for (int k = SW - 1; k >= 0; k--) begin
         if (f[k] == 1'b0) return SW - 1 - k;
      end
      return SW;
   endfunction

   function automatic logic [CH-1:0] route(input logic [TOT-1:0] act, input logic [11:0] bus);
      logic [CH-1:0] r;
      for (int c = 0; c < CH; c++) r[c] = bus[c*(SW+1) + dec(act[c*SW +: SW])];
      return r;
   endfunction

   // Model: mode 0 idle, 1 loading, 2 loaded.
   int              m_mode;
   int              m_cnt;
   logic [TOT-1:0]  m_sh;
   logic [TOT-1:0]  m_act;
   logic            m_err;
   logic [CH-1:0]   m_qreg;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_sh = '1; m_act = '1; m_err = 1'b0; m_qreg = '0;
      end else begin
         m_qreg = route(m_act, in_bus);
         m_err  = 1'b0;
         if (cfg_start) begin
            m_mode = 1; m_cnt = 0;
         end else begin
            if (cfg_commit && m_mode != 2) m_err = 1'b1;
            if (cfg_commit && m_mode == 2) begin
               m_act = m_sh; m_mode = 0;
            end else if (cfg_valid && m_mode == 1) begin
               m_sh = {m_sh[TOT-2:0], cfg_bit};
               m_cnt++;
               if (m_cnt == TOT) m_mode = 2;
            end
         end
      end
   end

   always begin
      @(posedge clk);
      #2;
      if (running) begin
         chk("q_comb",  q0,     route(m_act, in_bus));
         chk("q_reg",   q1,     m_qreg);
         chk("ready0",  ready0, m_mode == 1);
         chk("ready1",  ready1, m_mode == 1);
         chk("done0",   done0,  m_mode == 2);
         chk("done1",   done1,  m_mode == 2);
         chk("err0",    err0,   m_err);
         chk("err1",    err1,   m_err);
      end
   end

   // Drive inputs after the falling edge, return just after the next rising edge.
   task automatic cyc(input logic s, input logic v, input logic b, input logic c);
      @(negedge clk);
      cfg_start = s; cfg_valid = v; cfg_bit = b; cfg_commit = c;
      @(posedge clk);
      #3;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   task automatic load_bits(input logic [TOT-1:0] v, input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, v[TOT-1-i], 0);
   endtask

   task automatic set_bus(input logic [11:0] b);
      @(negedge clk);
      in_bus = b;
      #1;
   endtask

   initial begin
      rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_bit = 0; cfg_commit = 0;
      in_bus = 12'b100000_100000;
      idle(3);
      chk("rst_q_comb_default", q0, 2'b11);
      chk("rst_q_reg_zero",     q1, 2'b00);
      chk("rst_ready",          ready0, 1'b0);
      rst = 1'b0;
      idle(2);
      chk("q_reg_default", q1, 2'b11);

      // ch1 fuse 01111 -> cand 0, ch0 erased -> cand 5
      cyc(1, 0, 0, 0);
      chk("ready_after_start", ready0, 1'b1);
      load_bits(10'b0111111111, 10);
      chk("done_after_10", done0, 1'b1);
      chk("ready_after_10", ready0, 1'b0);
      idle(2);
      cyc(0, 0, 0, 1);
      chk("done_after_commit", done0, 1'b0);
      set_bus(12'b000001_100000);
      chk("route_basic", q0, 2'b11);
      idle(1);
      chk("route_basic_reg", q1, 2'b11);

      // ch0 fuse 11010 -> cand 2 (not 4), ch1 erased
      cyc(1, 0, 0, 0);
      load_bits(10'b11111_11010, 10);
      cyc(0, 0, 0, 1);
      set_bus(12'b000000_000100);
      chk("prio_bit2_hi", q0, 2'b01);
      set_bus(12'b000000_010000);
      chk("prio_bit4_only", q0, 2'b00);
      set_bus(12'b000000_000000);
      chk("prio_bit2_lo", q0, 2'b00);
      set_bus(12'b000000_000100);
      chk("prio_bit2_hi_again", q0, 2'b01);

      // Early commit after 7 bits
      cyc(1, 0, 0, 0);
      load_bits(10'b0000000000, 7);
      cyc(0, 0, 0, 1);
      chk("early_commit_err", err0, 1'b1);
      chk("early_commit_still_shift", ready0, 1'b1);
      chk("early_commit_route", q0, 2'b01);
      idle(1);
      chk("early_commit_err_pulse", err0, 1'b0);

      // Full load, then start+valid+commit together in FULL
      cyc(1, 0, 0, 0);
      load_bits(10'b0000000000, 10);
      chk("full_again", done0, 1'b1);
      cyc(1, 1, 1, 1);
      chk("abort_no_err", err0, 1'b0);
      chk("abort_shift", ready0, 1'b1);
      chk("abort_old_route", q0, 2'b01);
      load_bits(10'b0000000000, 9);
      chk("abort_count_reset", done0, 1'b0);
      load_bits(10'b0000000000, 1);
      chk("reload_full", done0, 1'b1);
      cyc(0, 0, 0, 1);
      set_bus(12'b000001_000001);
      chk("reload_route", q0, 2'b11);
      set_bus(12'b000000_000100);
      chk("reload_route_bit2", q0, 2'b00);

      // Reset mid-load, then commit attempt
      set_bus(12'b100000_100000);
      cyc(1, 0, 0, 0);
      load_bits(10'b1010000000, 4);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rst_mid_q_reg", q1, 2'b00);
      cyc(0, 0, 0, 1);
      chk("post_rst_commit_err", err0, 1'b1);
      chk("post_rst_route", q0, 2'b11);
      set_bus(12'b000001_000001);
      chk("post_rst_active_ones", q0, 2'b00);
      idle(2);

      running = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
